ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
Parametrised EX/MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush. It sits between the execute and memory stages. It carries the control bundle, ALU result, store data, destination register and zero flag. Unlike a plain always-load pipeline register, it supports back-pressure from MEM without combinational ready paths, inserts bubbles, and flushes on branch redirect.

Parameters:
XLEN, 32, width of alu_result and rs2_data
RD_W, 5, destination register index width
CTRL_W, 4, control bundle width; bit order {reg_write, mem_to_reg, mem_write, mem_read}, MSB first
CNT_W, 16, performance counter width (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept; driven directly from a register
in_ctrl  in  CTRL_W  control bundle
in_alu_result  in  XLEN  ALU result / address
in_rs2_data  in  XLEN  store data
in_rd  in  RD_W  destination register
in_zero  in  1  ALU zero flag
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM accepts the entry
out_ctrl  out  CTRL_W  control bundle; forced to 0 whenever out_valid=0
out_alu_result  out  XLEN  registered ALU result
out_rs2_data  out  XLEN  registered store data
out_rd  out  RD_W  registered destination
out_zero  out  1  registered zero flag

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_ctrl=0, out_alu_result=0, out_rs2_data=0, out_rd=0, out_zero=0, skid entry invalid and zeroed, in_ready=1. Reset has priority over flush and all transfers.
- Transfer rules: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main register (drives outputs) plus one skid register. Each holds a valid bit and a full payload.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 entry per cycle when out_ready is held at 1.
- Per edge, no flush, with the main register empty or draining:
  - skid valid: main <- skid, skid <- accepted input if any, else invalid.
  - skid empty: main <- accepted input if any, else main becomes invalid (bubble).
- Per edge, no flush, main full and not draining: an accepted input loads the skid register.
- Acceptance cannot occur while the skid is full, because in_ready=0 then.
- in_ready next = ~(skid valid after this edge). It is never a combinational function of out_ready.
- Ordering: strict FIFO. Entries are never duplicated or dropped except by flush.
- Flush (flush=1, reset=0):
  - main and skid become invalid and out_ctrl=0 on the next cycle; in_ready=1.
  - An input accepted in the same cycle is discarded.
  - Payload data registers hold their old values.
- Bubble: whenever out_valid=0, out_ctrl=0, so MEM/WB never see a stray mem_write or reg_write. The other out_* data fields are don't-care.
- Holding: while out_valid=1 and out_ready=0, all out_* fields are stable.
- Reset asserted mid-stall: both entries are lost; the stage behaves as after power-up.

Optional Feature:
Macro EX_MEM_PIPE_STAGE_PERF_CNT_EN.
- Defined: adds output ports stall_cycles [CNT_W] and bubble_cycles [CNT_W], both 0 at reset.
  - stall_cycles increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cycles increments each cycle with out_valid=0 and reset=0.
  - Both saturate at 2^CNT_W-1 and are unaffected by flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=1 with in_valid=1 and in_ctrl=4'b1111, then release -> out_valid=0, out_ctrl=0, in_ready=1. First accept of alu_result=0x0000_0040 appears at out_alu_result one cycle later with out_valid=1.
- Streaming: out_ready=1, 8 back-to-back inputs with rd=1..8 -> outputs rd=1..8 on consecutive cycles, in_ready stays 1, no gaps.
- Back-pressure: accept A (rd=3), then B (rd=4), with out_ready=0.
  - Required: in_ready=0 in the cycle after B is accepted, and outputs hold A.
  - Raise out_ready -> A, then B, then out_valid=0 with out_ctrl=0.
- Flush: with main=A and skid=B, assert flush for 1 cycle while in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears at the output.
- Reset during stall: with both entries full, pulse reset -> same state as the reset test, and no stale entry drains afterwards.
- Perf (macro defined):
  - Stall 5 cycles with out_valid=1 -> stall_cycles=5.
  - Idle with CNT_W=4 for 20 cycles -> bubble_cycles=15 (saturated).

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage: main register plus one skid entry carrying ctrl, ALU result, store data, rd and zero flag.
// Latency: 1 cycle from accept to out_valid; sustains 1 entry/cycle while out_ready stays high.
// Backpressure: in_ready is a register (~skid valid) and never depends combinationally on out_ready.
// Optional: define EX_MEM_PIPE_STAGE_PERF_CNT_EN to add saturating stall_cycles/bubble_cycles counters.
module ex_mem_pipe_stage #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_zero
`ifdef EX_MEM_PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cycles
`endif
);

    // CNT_W only sizes the optional counters, but must be sane in every build.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
        logic [RD_W-1:0]   rd;
        logic              zero;
    } pay_t;

    pay_t main_q, main_d;
    pay_t skid_q, skid_d;
    pay_t in_pay;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic in_ready_q, in_ready_d;
    logic accept;
    logic drain;

    assign in_pay = '{ctrl: in_ctrl, alu: in_alu_result, rs2: in_rs2_data,
                      rd: in_rd, zero: in_zero};

    assign accept = in_valid & in_ready_q;
    assign drain  = main_vld_q & out_ready;

    // Next-state: skid refills main first to keep FIFO order; payloads hold when not loaded.
    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = skid_q;
                skid_vld_d = accept;
                if (accept) begin
                    skid_d = in_pay;
                end
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_d = in_pay;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_d     = in_pay;
        end
        in_ready_d = ~skid_vld_d;
    end

    // State registers; reset clears both entries and reopens the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = main_vld_q;
    // Bubbles must never leak a stale reg_write/mem_write downstream.
    assign out_ctrl       = main_q.ctrl & {CTRL_W{main_vld_q}};
    assign out_alu_result = main_q.alu;
    assign out_rs2_data   = main_q.rs2;
    assign out_rd         = main_q.rd;
    assign out_zero       = main_q.zero;

`ifdef EX_MEM_PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating stall/bubble counters; flush does not touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_vld_q && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!main_vld_q && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: reset, streaming, back-pressure, flush, reset mid-stall.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
// Payload fields are derived from rd so every expected value follows from the table's rd.
module tb_ex_mem_pipe_stage;
    localparam int XLEN   = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   in_alu_result, in_rs2_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_zero;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_alu_result, out_rs2_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_zero;
`ifdef EX_MEM_PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cycles, bubble_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
        .in_rd(in_rd), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_alu_result(out_alu_result), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_zero(out_zero)
`ifdef EX_MEM_PIPE_STAGE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ev;
        logic [3:0]  ectrl;
        logic [4:0]  erd;
        logic        eir;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] alu_of(input logic [4:0] rd);
        return 32'(rd) << 6;
    endfunction

    function automatic logic [31:0] rs2_of(input logic [4:0] rd);
        return 32'hA5A5_0000 | 32'(rd);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic ev, input logic [3:0] ectrl, input logic [4:0] erd,
                       input logic eir);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.ctrl = ctrl; v.rd = rd;
        v.ev = ev; v.ectrl = ectrl; v.erd = erd; v.eir = eir;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [3:0] ctrl, input logic [4:0] rd);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        in_ctrl = ctrl; in_rd = rd;
        in_alu_result = alu_of(rd); in_rs2_data = rs2_of(rd); in_zero = rd[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Columns: rst fl iv ordy ctrl rd | exp: valid ctrl rd in_ready
        add(0,0,1,1,4'h8, 5'd1,  1,4'h8, 5'd1, 1);
        for (int k = 2; k <= 8; k++) add(0,0,1,1,4'h8, 5'(k), 1,4'h8, 5'(k), 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);
        // back-pressure: A(rd3) then B(rd4) into skid, rd5 refused
        add(0,0,1,0,4'h2, 5'd3,  1,4'h2, 5'd3, 1);
        add(0,0,1,0,4'h9, 5'd4,  1,4'h2, 5'd3, 0);
        add(0,0,1,0,4'h5, 5'd5,  1,4'h2, 5'd3, 0);
        add(0,0,0,1,4'h0, 5'd0,  1,4'h9, 5'd4, 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);
        // flush with both entries full, C offered
        add(0,0,1,0,4'h4, 5'd10, 1,4'h4, 5'd10, 1);
        add(0,0,1,0,4'h1, 5'd11, 1,4'h4, 5'd10, 0);
        add(0,1,1,0,4'hF, 5'd12, 0,4'h0, 5'd0, 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);
        // flush while an input is actually accepted: it is discarded
        add(0,0,1,1,4'hA, 5'd13, 1,4'hA, 5'd13, 1);
        add(0,1,1,1,4'h6, 5'd14, 0,4'h0, 5'd0, 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);
        // reset during stall with both entries full
        add(0,0,1,0,4'h3, 5'd15, 1,4'h3, 5'd15, 1);
        add(0,0,1,0,4'hC, 5'd16, 1,4'h3, 5'd15, 0);
        add(1,0,1,0,4'hF, 5'd17, 0,4'h0, 5'd0, 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);
        add(0,0,0,1,4'h0, 5'd0,  0,4'h0, 5'd0, 1);

        // Reset with a valid all-ones input pending
        drive(1,0,1,0,4'hF,5'd31);
        tick();
        tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_ctrl",  32'(out_ctrl), 32'd0);
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.out_alu",   out_alu_result, 32'd0);
        chk("rst.out_rs2",   out_rs2_data, 32'd0);
        chk("rst.out_rd",    32'(out_rd), 32'd0);
        chk("rst.out_zero",  32'(out_zero), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].ctrl, tbl[i].rd);
            tick();
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d.out_ctrl", i),  32'(out_ctrl),  32'(tbl[i].ectrl));
            chk($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].eir));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d.out_rd", i),   32'(out_rd), 32'(tbl[i].erd));
                chk($sformatf("v%0d.out_alu", i),  out_alu_result, alu_of(tbl[i].erd));
                chk($sformatf("v%0d.out_rs2", i),  out_rs2_data, rs2_of(tbl[i].erd));
                chk($sformatf("v%0d.out_zero", i), 32'(out_zero), 32'(tbl[i].erd[0]));
            end
        end

        // After reset mid-stall the data registers are back at zero
        chk("rststall.out_alu", out_alu_result, 32'd0);
        chk("rststall.out_rd",  32'(out_rd), 32'd0);

        // A fresh accept after that reset comes through alone
        drive(0,0,1,1,4'hB,5'd20);
        tick();
        drive(0,0,0,1,4'h0,5'd0);
        chk("post.out_valid", 32'(out_valid), 32'd1);
        chk("post.out_rd",    32'(out_rd), 32'd20);
        chk("post.out_ctrl",  32'(out_ctrl), 32'hB);
        tick();
        chk("post.drained",   32'(out_valid), 32'd0);

`ifdef EX_MEM_PIPE_STAGE_PERF_CNT_EN
        drive(1,0,0,1,4'h0,5'd0);
        tick();
        chk("perf.rst_stall",  32'(stall_cycles), 32'd0);
        chk("perf.rst_bubble", 32'(bubble_cycles), 32'd0);
        drive(0,0,0,1,4'h0,5'd0);
        for (int c = 0; c < 20; c++) tick();
        chk("perf.bubble_sat", 32'(bubble_cycles), 32'd15);
        chk("perf.idle_stall", 32'(stall_cycles), 32'd0);
        drive(1,0,0,1,4'h0,5'd0);
        tick();
        drive(0,0,1,0,4'h8,5'd21);
        tick();
        drive(0,0,0,0,4'h0,5'd0);
        for (int c = 0; c < 5; c++) tick();
        chk("perf.stall5",  32'(stall_cycles), 32'd5);
        chk("perf.bubble1", 32'(bubble_cycles), 32'd1);
        drive(0,1,0,0,4'h0,5'd0);
        tick();
        chk("perf.flush_keeps", 32'(stall_cycles), 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
